fifo_ctrl: RTL and testbench

- Pointer and flag controller that turns a plain dual-port RAM into a synchronous FIFO.
- Sits directly upstream of the RAM. Drives its write enable, write address and read address from producer `wr` and consumer `rd` requests.
- Produces `full`, `empty` and an occupancy count.
- The RAM read is combinational, so the word at `addr_rd` is the FIFO head while `empty` = 0. The result is first-word-fall-through behaviour.

---
 rtl/fifo_ctrl.sv | 71 +++++++
 tb/tb_fifo_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FWFT FIFO pointer/flag controller for a dual-port RAM; optional almost flags via FIFO_CTRL_ALMOST_FLAGS_EN
module fifo_ctrl #(
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  we,
    output logic [addr_width-1:0] addr_wr,
    output logic [addr_width-1:0] addr_rd,
    output logic                  full,
    output logic                  empty,
    output logic [addr_width:0]   count,
    output logic                  ovf,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  udf
);
    localparam logic [addr_width:0] depth = (addr_width+1)'(2**addr_width);
    logic                  wr_ok, rd_ok, wr_only, rd_only;
    logic [addr_width-1:0] addr_wr_nx, addr_rd_nx;
    logic [addr_width:0]   count_nx;
    assign wr_ok      = wr & ~full & ~reset;
    assign rd_ok      = rd & ~empty & ~reset;
    assign we         = wr_ok;
    assign wr_only    = wr_ok & ~rd_ok;
    assign rd_only    = rd_ok & ~wr_ok;
    assign addr_wr_nx = addr_wr + 1'b1;
    assign addr_rd_nx = addr_rd + 1'b1;
    assign count_nx   = wr_only ? count + 1'b1 : rd_only ? count - 1'b1 : count;
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_wr <= '0;
            addr_rd <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            ovf   <= ovf | (wr & full);
            udf   <= udf | (rd & empty);
            count <= count_nx;
            if (wr_ok) addr_wr <= addr_wr_nx;
            if (rd_ok) addr_rd <= addr_rd_nx;
            // flags only move when exactly one side is accepted
            if (wr_only) begin
                empty <= 1'b0;
                full  <= addr_wr_nx == addr_rd;
            end
            if (rd_only) begin
                full  <= 1'b0;
                empty <= addr_rd_nx == addr_wr;
            end
        end
    end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= count_nx >= depth - 1'b1;
            almost_empty <= count_nx <= 1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed plan plus random traffic against a queue-based FIFO model with a bench-side RAM.
module tb_fifo_ctrl;
    logic       clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0;
    logic       we, full, empty, ovf, udf;
    logic [1:0] addr_wr, addr_rd;
    logic [2:0] count;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic       almost_full, almost_empty;
`endif
    logic [7:0] din = 8'h00;
    logic [7:0] mem [4];
    int         checks = 0, errors = 0;
    int         q[$];
    int         nw = 0, nr = 0;
    bit         movf = 0, mudf = 0;

    fifo_ctrl #(.addr_width(2)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .we(we),
        .addr_wr(addr_wr), .addr_rd(addr_rd), .full(full), .empty(empty),
        .count(count), .ovf(ovf),
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .udf(udf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (we) mem[addr_wr] <= din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit w, input bit r, input bit rs, input logic [7:0] d);
        int sz;
        wr = w; rd = r; reset = rs; din = d;
        sz = q.size();
        #1 chk("we", 32'(we), 32'(w && !rs && sz < 4));
        @(posedge clk);
        if (rs) begin
            q.delete(); nw = 0; nr = 0; movf = 0; mudf = 0;
        end else begin
            if (w && sz == 4) movf = 1;
            if (r && sz == 0) mudf = 1;
            if (r && sz > 0) begin void'(q.pop_front()); nr++; end
            if (w && sz < 4) begin q.push_back(int'(d)); nw++; end
        end
        @(negedge clk);
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 4));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("addr_wr", 32'(addr_wr), 32'(nw % 4));
        chk("addr_rd", 32'(addr_rd), 32'(nr % 4));
        chk("ovf", 32'(ovf), 32'(movf));
        chk("udf", 32'(udf), 32'(mudf));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
`endif
        if (q.size() > 0) chk("head", 32'(mem[addr_rd]), 32'(q[0]));
    endtask

    initial begin
        step(0, 0, 1, 8'h00);
        repeat (3) step(0, 0, 0, 8'h00);
        step(1, 0, 1, 8'h11);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'hA0 + 8'(i));
        step(1, 0, 0, 8'hEE);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(1, 0, 0, 8'h21);
        step(1, 0, 0, 8'h22);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 8'h30 + 8'(i));
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h40);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h41 + 8'(i));
        step(1, 1, 0, 8'h50);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0, 8'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
